// File: rtl/usr_pkg.sv
// usr_pkg: shared encodings for the universal shift register.
// Mode codes (USR_HOLD..USR_BURST) and burst FSM states.
package usr_pkg;

  localparam logic [2:0] USR_HOLD  = 3'b000;
  localparam logic [2:0] USR_SHR   = 3'b001;
  localparam logic [2:0] USR_SHL   = 3'b010;
  localparam logic [2:0] USR_LOAD  = 3'b011;
  localparam logic [2:0] USR_ROR   = 3'b100;
  localparam logic [2:0] USR_ROL   = 3'b101;
  localparam logic [2:0] USR_ASR   = 3'b110;
  localparam logic [2:0] USR_BURST = 3'b111;

  typedef enum logic {
    USR_IDLE     = 1'b0,
    USR_BURST_ST = 1'b1
  } usr_state_e;

endpackage

// File: rtl/usr_burst_ctrl.sv
// usr_burst_ctrl: burst FSM and down-counter.
// In: clk, rst_n, ena, start, burst_len. Out: shift_en, busy, done.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= USR_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    shift_en = 1'b0;
    if (ena) begin
      done_d = 1'b0;
      unique case (state_q)
        USR_IDLE: begin
          if (start) begin
            cnt_d = burst_len;
            // Zero-length burst completes without ever going busy.
            if (burst_len == '0) done_d = 1'b1;
            else state_d = USR_BURST_ST;
          end
        end
        USR_BURST_ST: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = USR_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = USR_IDLE;
      endcase
    end
  end

  assign busy = (state_q == USR_BURST_ST);
  assign done = done_q;

endmodule

// File: rtl/usr_param_shift_reg.sv
// usr_param_shift_reg: WIDTH-bit universal shift register with
// shift/rotate/ASR/load and, with `USR_BURST_EN, a counted burst.
// In: clk, rst_n, ena, mode, sin_left, sin_right, pin,
//     burst_len, burst_dir.
// Out: q, sout_right, sout_left, busy, done.
module usr_param_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [2:0]       mode,
  input  logic             sin_left,
  input  logic             sin_right,
  input  logic [WIDTH-1:0] pin,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] q,
  output logic             sout_right,
  output logic             sout_left,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] shr, shl;
  logic             shift_en;
  logic             dir_q;

  assign shr = {sin_left, q_q[WIDTH-1:1]};
  assign shl = {q_q[WIDTH-2:0], sin_right};

`ifdef USR_BURST_EN
  logic dir_d;
  logic start;

  assign start = (mode == USR_BURST) && !busy;

  usr_burst_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .burst_len (burst_len),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done)
  );

  assign dir_d = (ena && start) ? burst_dir : dir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end
`else
  logic unused_burst;

  assign unused_burst = ^{burst_len, burst_dir};
  assign shift_en     = 1'b0;
  assign dir_q        = 1'b0;
  assign busy         = 1'b0;
  assign done         = 1'b0;
`endif

  always_comb begin
    q_d = q_q;
    if (ena && shift_en) begin
      q_d = dir_q ? shl : shr;
    end else if (ena && !busy) begin
      unique case (1'b1)
        (mode == USR_HOLD):  q_d = q_q;
        (mode == USR_SHR):   q_d = shr;
        (mode == USR_SHL):   q_d = shl;
        (mode == USR_LOAD):  q_d = pin;
        (mode == USR_ROR):   q_d = {q_q[0], q_q[WIDTH-1:1]};
        (mode == USR_ROL):   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        (mode == USR_ASR):   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        // Burst start edge leaves q untouched.
        (mode == USR_BURST): q_d = q_q;
        default:             q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q          = q_q;
  assign sout_right = q_q[0];
  assign sout_left  = q_q[WIDTH-1];

endmodule

// File: tb/tb_usr_param_shift_reg.sv
// tb_usr_param_shift_reg: directed bench, WIDTH=8, scoreboard queue.
// Burst scenarios run only when USR_BURST_EN is defined.
module tb_usr_param_shift_reg;
  import usr_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] mode;
  logic       sin_left;
  logic       sin_right;
  logic [7:0] pin;
  logic [3:0] burst_len;
  logic       burst_dir;
  logic [7:0] q;
  logic       sout_right;
  logic       sout_left;
  logic       busy;
  logic       done;

  int tests;
  int fails;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  usr_param_shift_reg #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .mode       (mode),
    .sin_left   (sin_left),
    .sin_right  (sin_right),
    .pin        (pin),
    .burst_len  (burst_len),
    .burst_dir  (burst_dir),
    .q          (q),
    .sout_right (sout_right),
    .sout_left  (sout_left),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input logic [7:0] eq,
                      input logic eb, input logic ed);
    exp_t e;
    e.tag  = t;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL sb_empty: no expectation queued");
    end else begin
      e = sb.pop_front();
      tests++;
      assert (q === e.q) else begin
        fails++;
        $error("FAIL %s q: got %h want %h", e.tag, q, e.q);
      end
      tests++;
      assert (busy === e.busy) else begin
        fails++;
        $error("FAIL %s busy: got %b want %b", e.tag, busy, e.busy);
      end
      tests++;
      assert (done === e.done) else begin
        fails++;
        $error("FAIL %s done: got %b want %b", e.tag, done, e.done);
      end
      tests++;
      assert ({sout_left, sout_right} === {e.q[7], e.q[0]}) else begin
        fails++;
        $error("FAIL %s sout: got %b%b want %b%b", e.tag,
               sout_left, sout_right, e.q[7], e.q[0]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk();
  endtask

  task automatic op(input logic [2:0] m, input logic [7:0] p,
                    input string t, input logic [7:0] eq);
    mode = m;
    pin  = p;
    push(t, eq, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    mode      = USR_HOLD;
    sin_left  = 1'b0;
    sin_right = 1'b0;
    pin       = 8'h00;
    burst_len = 4'd0;
    burst_dir = 1'b0;

    push("reset", 8'h00, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;

    op(USR_LOAD, 8'hA5, "load_a5", 8'hA5);

    rst_n = 1'b0;
    push("async_rst", 8'h00, 1'b0, 1'b0);
    #1;
    chk();
    rst_n = 1'b1;

    op(USR_LOAD, 8'h81, "load_81", 8'h81);
    op(USR_ROR,  8'h00, "ror", 8'hC0);
    op(USR_ROL,  8'h00, "rol1", 8'h81);
    op(USR_ROL,  8'h00, "rol2", 8'h03);
    op(USR_LOAD, 8'h80, "load_80", 8'h80);
    op(USR_ASR,  8'h00, "asr", 8'hC0);
    sin_left = 1'b0;
    op(USR_SHR,  8'h00, "shr", 8'h60);
    sin_right = 1'b1;
    op(USR_SHL,  8'h00, "shl", 8'hC1);
    op(USR_HOLD, 8'hFF, "hold", 8'hC1);
    ena = 1'b0;
    op(USR_LOAD, 8'h00, "ena_low", 8'hC1);
    ena = 1'b1;

`ifdef USR_BURST_EN
    op(USR_LOAD, 8'h0F, "load_0f", 8'h0F);
    burst_len = 4'd3;
    burst_dir = 1'b1;
    sin_right = 1'b1;
    mode      = USR_BURST;
    push("b3_start", 8'h0F, 1'b1, 1'b0);
    step();
    mode      = USR_LOAD;
    pin       = 8'h00;
    burst_dir = 1'b0;
    push("b3_s1", 8'h1F, 1'b1, 1'b0);
    step();
    mode = USR_SHR;
    push("b3_s2", 8'h3F, 1'b1, 1'b0);
    step();
    mode = USR_ROR;
    push("b3_s3", 8'h7F, 1'b0, 1'b1);
    step();
    mode = USR_HOLD;
    push("b3_after", 8'h7F, 1'b0, 1'b0);
    step();

    burst_len = 4'd0;
    mode      = USR_BURST;
    push("b0_start", 8'h7F, 1'b0, 1'b1);
    step();
    mode = USR_HOLD;
    push("b0_after", 8'h7F, 1'b0, 1'b0);
    step();

    op(USR_LOAD, 8'h00, "load_00", 8'h00);
    burst_len = 4'd5;
    burst_dir = 1'b0;
    sin_left  = 1'b1;
    mode      = USR_BURST;
    push("b5_start", 8'h00, 1'b1, 1'b0);
    step();
    mode = USR_HOLD;
    push("b5_s1", 8'h80, 1'b1, 1'b0);
    step();
    push("b5_s2", 8'hC0, 1'b1, 1'b0);
    step();
    ena = 1'b0;
    push("b5_stall1", 8'hC0, 1'b1, 1'b0);
    step();
    push("b5_stall2", 8'hC0, 1'b1, 1'b0);
    step();
    ena = 1'b1;
    push("b5_s3", 8'hE0, 1'b1, 1'b0);
    step();
    push("b5_s4", 8'hF0, 1'b1, 1'b0);
    step();
    push("b5_s5", 8'hF8, 1'b0, 1'b1);
    step();
    push("b5_after", 8'hF8, 1'b0, 1'b0);
    step();

    op(USR_LOAD, 8'h00, "load_00b", 8'h00);
    burst_len = 4'd4;
    burst_dir = 1'b1;
    sin_right = 1'b1;
    mode      = USR_BURST;
    push("ab_start", 8'h00, 1'b1, 1'b0);
    step();
    mode = USR_HOLD;
    push("ab_s1", 8'h01, 1'b1, 1'b0);
    step();
    rst_n = 1'b0;
    push("ab_rst", 8'h00, 1'b0, 1'b0);
    #1;
    chk();
    rst_n = 1'b1;
    push("ab_nodone", 8'h00, 1'b0, 1'b0);
    step();
    push("ab_nodone2", 8'h00, 1'b0, 1'b0);
    step();
`else
    op(USR_LOAD, 8'h5A, "load_5a", 8'h5A);
    burst_len = 4'd3;
    burst_dir = 1'b1;
    op(USR_BURST, 8'h00, "m111_1", 8'h5A);
    op(USR_BURST, 8'h00, "m111_2", 8'h5A);
    burst_len = 4'd0;
    op(USR_BURST, 8'h00, "m111_3", 8'h5A);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
